// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline IF/MA stages, the memory-port arbiter and the unified memory.
// The arbiter connects through the slave modport; the pipeline/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic [3:0]            d_read;
    logic [2:0]            d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  busywait;
    logic [31:0]           stall_cycles;

    logic [3:0]            mem_read;
    logic [2:0]            mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, d_rdata, busywait, stall_cycles,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, d_rdata, busywait, stall_cycles,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first,
// and holds the pipeline via busywait until every pending access has been captured.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter logic [3:0]  IFETCH_READ_CODE = 4'b1010
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;

    logic d_req, d_is_write, d_pend, i_pend, busy;

    // Request decode; a simultaneous read+write enable is treated as a write only.
    always_comb begin
        d_req      = bus.d_read[3] | bus.d_write[2];
        d_is_write = bus.d_write[2];
        d_pend     = d_req & ~d_done_q;
        i_pend     = bus.i_req & ~i_done_q;
        busy       = d_pend | i_pend;
    end

    // Next-state, capture and release logic.
    always_comb begin
        state_d        = state_q;
        i_done_d       = i_done_q;
        d_done_d       = d_done_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        stall_cycles_d = busy ? stall_cycles_q + CNT_WIDTH'(1) : stall_cycles_q;

        case (state_q)
            ST_IDLE: begin
                if (d_pend) begin
                    state_d = ST_DATA;
                end else if (i_pend) begin
                    state_d = ST_INST;
                end
            end
            ST_DATA: begin
                if (bus.mem_ready) begin
                    if (!d_is_write) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                    d_done_d = 1'b1;
                    state_d  = i_pend ? ST_INST : ST_IDLE;
                end
            end
            ST_INST: begin
                if (bus.mem_ready) begin
                    i_rdata_d = bus.mem_rdata;
                    i_done_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The pipeline advances on this edge, so the next cycle sees fresh requests.
        if (!busy) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            i_done_q       <= 1'b0;
            d_done_q       <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            i_done_q       <= i_done_d;
            d_done_q       <= d_done_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Memory-side drive depends only on the state register; requester inputs are frozen meanwhile.
    always_comb begin
        bus.mem_read  = 4'b0000;
        bus.mem_write = 3'b000;
        bus.mem_addr  = ADDR_WIDTH'(0);
        bus.mem_wdata = DATA_WIDTH'(0);
        case (state_q)
            ST_DATA: begin
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.mem_read  = d_is_write ? 4'b0000 : bus.d_read;
                bus.mem_write = bus.d_write;
            end
            ST_INST: begin
                bus.mem_addr = bus.i_addr;
                bus.mem_read = IFETCH_READ_CODE;
            end
            default: ;
        endcase
    end

    assign bus.busywait     = busy;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of whole transactions against a latency-programmable
// memory model, plus hand sequences for IDLE mem_ready, mid-access reset and counter wrap.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .IFETCH_READ_CODE(4'b1010)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Memory model: completes an access once it has been presented for more than lat cycles.
    int unsigned lat        = 1;
    logic        ready_idle = 1'b0;
    int unsigned cnt        = 0;
    int unsigned wr_cnt     = 0;
    logic [31:0] wr_data    = '0;
    logic        mem_active;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);
    assign mem_active    = (bus.mem_read != 4'b0000) || (bus.mem_write != 3'b000);

    always @(posedge clk) begin
        if (rst || bus.mem_ready || !mem_active) cnt <= 0;
        else                                     cnt <= cnt + 1;
        if (!rst && bus.mem_ready && bus.mem_write != 3'b000) begin
            wr_cnt  <= wr_cnt + 1;
            wr_data <= bus.mem_wdata;
        end
    end

    always @(negedge clk) bus.mem_ready = (mem_active && cnt >= lat) || ready_idle;

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic [3:0]  d_read;
        logic [2:0]  d_write;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int unsigned lat;
        int unsigned busy;
        logic [31:0] first_addr;
        int unsigned data_cyc;
        int unsigned inst_cyc;
        logic [3:0]  dmread;
        logic [2:0]  dmwrite;
        int unsigned writes;
        logic [31:0] wdata;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
        logic [31:0] stall;
    } vec_t;

    vec_t vecs [8];
    vec_t wrap_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int unsigned busy = 0;
        int unsigned dcyc = 0;
        int unsigned icyc = 0;
        int unsigned bad  = 0;
        int unsigned w0;
        logic [31:0] first = '0;
        bit          seen  = 1'b0;
        bit          done  = 1'b0;
        @(negedge clk);
        lat          = v.lat;
        w0           = wr_cnt;
        bus.i_req    = v.i_req;
        bus.i_addr   = v.i_addr;
        bus.d_read   = v.d_read;
        bus.d_write  = v.d_write;
        bus.d_addr   = v.d_addr;
        bus.d_wdata  = v.d_wdata;
        for (int k = 0; k < 30 && !done; k++) begin
            #1;
            if (mem_active) begin
                if (!seen) begin
                    first = bus.mem_addr;
                    seen  = 1'b1;
                end
                if ((v.d_read[3] || v.d_write[2]) && bus.mem_addr == v.d_addr) begin
                    dcyc++;
                    if (bus.mem_read !== v.dmread || bus.mem_write !== v.dmwrite ||
                        bus.mem_wdata !== v.d_wdata) bad++;
                end else begin
                    icyc++;
                    if (bus.mem_read !== 4'b1010 || bus.mem_write !== 3'b000 ||
                        bus.mem_addr !== v.i_addr || bus.mem_wdata !== 32'h0) bad++;
                end
            end
            if (bus.busywait) begin
                busy++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        chk({tag, " released"}, 32'(done), 32'd1);
        bus.i_req   = 1'b0;
        bus.d_read  = 4'b0000;
        bus.d_write = 3'b000;
        @(posedge clk);
        #1;
        chk({tag, " busy_cycles"}, busy, v.busy);
        if (v.data_cyc + v.inst_cyc != 0) chk({tag, " first_addr"}, first, v.first_addr);
        chk({tag, " data_cycles"}, dcyc, v.data_cyc);
        chk({tag, " inst_cycles"}, icyc, v.inst_cyc);
        chk({tag, " bad_drive"}, bad, 32'd0);
        chk({tag, " writes"}, wr_cnt - w0, v.writes);
        if (v.writes != 0) chk({tag, " wdata"}, wr_data, v.wdata);
        chk({tag, " i_rdata"}, bus.i_rdata, v.i_rdata);
        chk({tag, " d_rdata"}, bus.d_rdata, v.d_rdata);
        chk({tag, " stall_cycles"}, bus.stall_cycles, v.stall);
        chk({tag, " idle_busywait"}, 32'(bus.busywait), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // i_req i_addr d_read d_write d_addr d_wdata lat busy first dcyc icyc dmread dmwrite writes wdata i_rdata d_rdata stall
        vecs[0] = '{1'b1, 32'h0,  4'h0,    3'h0,    32'h0,   32'h0,        1, 3, 32'h0,   0, 2, 4'h0,    3'h0,    0, 32'h0,
                    32'h0050_0093, 32'h0, 32'd3};
        vecs[1] = '{1'b1, 32'h4,  4'b1010, 3'h0,    32'h100, 32'h0,        1, 5, 32'h100, 2, 2, 4'b1010, 3'h0,    0, 32'h0,
                    32'h00A0_0113, 32'hDEAD_BEEF, 32'd8};
        vecs[2] = '{1'b1, 32'h8,  4'h0,    3'b110,  32'h200, 32'h1234_5678, 1, 5, 32'h200, 2, 2, 4'h0,    3'b110,  1, 32'h1234_5678,
                    32'hA5A5_A5AD, 32'hDEAD_BEEF, 32'd13};
        vecs[3] = '{1'b1, 32'hC,  4'b1010, 3'b101,  32'h300, 32'hCAFE_F00D, 1, 5, 32'h300, 2, 2, 4'h0,    3'b101,  1, 32'hCAFE_F00D,
                    32'hA5A5_A5A9, 32'hDEAD_BEEF, 32'd18};
        vecs[4] = '{1'b0, 32'h0,  4'b1100, 3'h0,    32'h104, 32'h0,        1, 3, 32'h104, 2, 0, 4'b1100, 3'h0,    0, 32'h0,
                    32'hA5A5_A5A9, 32'hA5A5_A4A1, 32'd21};
        vecs[5] = '{1'b0, 32'h0,  4'h0,    3'h0,    32'h0,   32'h0,        1, 0, 32'h0,   0, 0, 4'h0,    3'h0,    0, 32'h0,
                    32'hA5A5_A5A9, 32'hA5A5_A4A1, 32'd21};
        vecs[6] = '{1'b1, 32'h10, 4'h0,    3'h0,    32'h0,   32'h0,        0, 2, 32'h10,  0, 1, 4'h0,    3'h0,    0, 32'h0,
                    32'hA5A5_A5B5, 32'hA5A5_A4A1, 32'd23};
        vecs[7] = '{1'b1, 32'h14, 4'b1010, 3'h0,    32'h108, 32'h0,        0, 3, 32'h108, 1, 1, 4'b1010, 3'h0,    0, 32'h0,
                    32'hA5A5_A5B1, 32'hA5A5_A4AD, 32'd26};
        wrap_v  = '{1'b1, 32'h30, 4'h0,    3'h0,    32'h0,   32'h0,        1, 3, 32'h30,  0, 2, 4'h0,    3'h0,    0, 32'h0,
                    32'hA5A5_A595, 32'h0, 32'h0000_0001};

        rst         = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = '0;
        bus.d_write = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset busywait", 32'(bus.busywait), 32'd0);
        chk("reset mem_read", 32'(bus.mem_read), 32'd0);
        chk("reset mem_write", 32'(bus.mem_write), 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'd0);
        chk("reset i_rdata", bus.i_rdata, 32'd0);
        chk("reset d_rdata", bus.d_rdata, 32'd0);
        chk("reset stall_cycles", bus.stall_cycles, 32'd0);

        for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // mem_ready pulsing while idle must not capture anything.
        @(posedge clk);
        #2 ready_idle = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        ready_idle = 1'b0;
        chk("idle_ready i_rdata", bus.i_rdata, 32'hA5A5_A5B1);
        chk("idle_ready d_rdata", bus.d_rdata, 32'hA5A5_A4AD);
        chk("idle_ready busywait", 32'(bus.busywait), 32'd0);
        chk("idle_ready stall_cycles", bus.stall_cycles, 32'd26);

        // Reset while an instruction fetch waits on a slow memory.
        @(negedge clk);
        lat        = 3;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h20;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mid pre mem_read", 32'(bus.mem_read), 32'hA);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mid mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mid i_rdata", bus.i_rdata, 32'd0);
        chk("rst_mid d_rdata", bus.d_rdata, 32'd0);
        chk("rst_mid stall_cycles", bus.stall_cycles, 32'd0);
        chk("rst_mid state", 32'(dut.state_q), 32'd0);
        chk("rst_mid i_done", 32'(dut.i_done_q), 32'd0);
        chk("rst_mid d_done", 32'(dut.d_done_q), 32'd0);
        @(negedge clk);
        bus.i_req = 1'b0;
        rst       = 1'b0;
        @(negedge clk);

        // Counter wrap from a preloaded near-full value.
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.stall_cycles_q;
        #1;
        chk("wrap preload", bus.stall_cycles, 32'hFFFF_FFFE);
        run_vec("wrap", wrap_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
